// File: rtl/dac_cmd_sender.sv
// Command initiator for the DAC board UART protocol: frames opcode + payload bytes
// onto a uart_top tx strobe interface and collects the 2-byte RD_DAT_CNT reply.
module dac_cmd_sender #(
  parameter logic [23:0] RSP_TIMEOUT = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op,
  input  logic [31:0] cmd_payload,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  output logic        done,
  output logic        err,
  output logic [15:0] rsp_data,
  output logic        rsp_valid
);

  localparam int unsigned OP_W   = 5;
  localparam int unsigned PAY_W  = 32;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TO_W   = 24;
  localparam int unsigned BYTE_W = 8;
  localparam logic [OP_W-1:0] OP_RD_DAT_CNT = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GUARD,
    S_WAIT_TX,
    S_RSP_LO,
    S_RSP_HI
  } state_t;

  state_t              state;
  logic [OP_W-1:0]     op_q;
  logic [PAY_W-1:0]    pay_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    n_q;
  logic [TO_W-1:0]     to_cnt;
  logic [BYTE_W-1:0]   lo_q;

  logic                acc_legal_c;
  logic [IDX_W-1:0]    acc_n_c;
  logic [PAY_W-1:0]    acc_pay_c;
  logic [BYTE_W-1:0]   cur_byte_c;
  logic                to_hit_c;

  // Decode frame length and pre-mask the payload so sending is a plain byte shift.
  always_comb begin
    acc_legal_c = 1'b1;
    acc_n_c     = '0;
    acc_pay_c   = '0;
    case (cmd_op)
      5'd0, 5'd3, 5'd4, 5'd5, 5'd13, 5'd17: begin
        acc_n_c = 3'd0;
      end
      5'd2: begin
        acc_n_c   = 3'd1;
        acc_pay_c = {29'd0, cmd_payload[2:0]};
      end
      5'd8: begin
        acc_n_c   = 3'd1;
        acc_pay_c = {24'd0, cmd_payload[7:0]};
      end
      5'd1: begin
        acc_n_c   = 3'd2;
        acc_pay_c = {17'd0, cmd_payload[14:0]};
      end
      5'd11: begin
        acc_n_c   = 3'd2;
        acc_pay_c = {16'd0, cmd_payload[15:0]};
      end
      5'd9, 5'd10, 5'd19: begin
        acc_n_c   = 3'd4;
        acc_pay_c = cmd_payload;
      end
      default: acc_legal_c = 1'b0;
    endcase
  end

  always_comb begin
    cur_byte_c = '0;
    case (idx_q)
      3'd0:    cur_byte_c = {3'b000, op_q};
      3'd1:    cur_byte_c = pay_q[7:0];
      3'd2:    cur_byte_c = pay_q[15:8];
      3'd3:    cur_byte_c = pay_q[23:16];
      default: cur_byte_c = pay_q[31:24];
    endcase
  end

  assign to_hit_c = (to_cnt == TO_W'(RSP_TIMEOUT - 24'd1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
      op_q        <= '0;
      pay_q       <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      to_cnt      <= '0;
      lo_q        <= '0;
    end else begin
      new_tx_data <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rsp_valid   <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            pay_q     <= acc_pay_c;
            n_q       <= acc_n_c;
            idx_q     <= '0;
            // Illegal opcodes are swallowed: nothing goes on the wire.
            if (acc_legal_c) state <= S_SEND;
            else             err   <= 1'b1;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_data     <= cur_byte_c;
            new_tx_data <= 1'b1;
            state       <= S_GUARD;
          end
        end
        // tx_busy only rises the cycle after the strobe, so it is not trusted here.
        S_GUARD: state <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (!tx_busy) begin
            if (idx_q == n_q) begin
              if (op_q == OP_RD_DAT_CNT) begin
                to_cnt <= '0;
                state  <= S_RSP_LO;
              end else begin
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                state     <= S_IDLE;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              state <= S_SEND;
            end
          end
        end
        S_RSP_LO: begin
          if (new_rx_data) begin
            lo_q   <= rx_data;
            to_cnt <= '0;
            state  <= S_RSP_HI;
          end else if (to_hit_c) begin
            err       <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        S_RSP_HI: begin
          if (new_rx_data) begin
            rsp_data  <= {1'b0, rx_data[6:0], lo_q};
            rsp_valid <= 1'b1;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else if (to_hit_c) begin
            err       <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
